dfe_coef_loader: RTL and testbench
==================================

Name: dfe_coef_loader

Overview:
- Upstream configuration stage for the parallel DFE receiver.
- Fetches PULSE_RESPONSE_LENGTH 64-bit pulse-response words (coefficient m in [31:16], shift y in [15:0]) from on-chip memory and streams them into the DFE's load_mem/location/mem_data port.
- Waits for the DFE's done_wait and then raises loaded, which is used to gate symbol injection into the DFE.

Parameters:
- PULSE_RESPONSE_LENGTH, 5, number of coefficient words to transfer (1..255).
- RD_LATENCY, 1, OCM read latency in cycles (1..4).
- BASE_ADDR, 0, OCM word address of coefficient 0.
- ADDR_WIDTH, 10, OCM address width.
- TRAILER_BEATS, 2, extra load_mem beats after the last word (the DFE done counter expects LENGTH+2 beats).
- TIMEOUT_CYCLES, 1024, maximum wait for done_wait.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to (re)load coefficients
- ocm_rd_en  out  1  OCM read strobe
- ocm_addr  out  ADDR_WIDTH  OCM read address
- ocm_rdata  in  64  OCM read data, valid RD_LATENCY cycles after ocm_rd_en
- load_mem  out  1  write beat to DFE
- location  out  8  coefficient index for the current beat
- mem_data  out  64  coefficient word for the current beat
- done_wait  in  1  DFE reports load complete
- busy  out  1  transfer in progress
- loaded  out  1  coefficients resident; DFE may accept symbols
- timeout_err  out  1  sticky: done_wait not seen within TIMEOUT_CYCLES

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, FSM in IDLE, all counters 0. Reset mid-transfer aborts the transfer immediately; no partial beats are emitted after release.
- FSM states: IDLE, READ, DRAIN, TRAIL, WAIT_DONE, LOADED, ERROR.
- IDLE/LOADED/ERROR:
  - start=1 moves to READ next cycle.
  - Clears loaded and timeout_err.
  - Resets the read index rd_idx and the beat index.
- READ:
  - ocm_rd_en=1 and ocm_addr=BASE_ADDR+rd_idx every cycle.
  - rd_idx increments from 0 to LENGTH-1.
  - After issuing LENGTH-1, go to DRAIN.
- Return path:
  - A RD_LATENCY-deep valid/index shift register tracks in-flight reads.
  - When an entry exits: load_mem=1, location=its index, mem_data=ocm_rdata, all registered (one cycle after the OCM data is valid).
  - Total latency from the first ocm_rd_en to the first load_mem is RD_LATENCY+1 cycles.
  - Beats are contiguous; there is no backpressure.
- DRAIN: wait until the pipeline is empty, then go to TRAIL.
- TRAIL:
  - load_mem stays asserted for TRAILER_BEATS cycles, repeating location=LENGTH-1 and the last mem_data (an idempotent rewrite).
  - Then go to WAIT_DONE.
  - With TRAILER_BEATS=0, go straight to WAIT_DONE.
- Beat count: total load_mem beats = LENGTH+TRAILER_BEATS, with no gaps.
- WAIT_DONE:
  - load_mem=0 and the timeout counter increments.
  - done_wait=1 (including when already high on entry) moves to LOADED next cycle; loaded=1.
  - Counter reaching TIMEOUT_CYCLES-1 without done_wait moves to ERROR; timeout_err=1 (sticky).
  - done_wait and expiry in the same cycle: done_wait wins.
- busy: 1 in READ, DRAIN, TRAIL and WAIT_DONE; otherwise 0.
- start while busy: ignored, no restart.
- location width: index zero-extended to 8 bits.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package rx_cfg_pkg holds:
  - the state enum type loader_state_t;
  - localparams COEF_M_HI=31, COEF_M_LO=16, COEF_Y_HI=15, COEF_Y_LO=0;
  - the word-width constant OCM_WORD_W=64.
- One sub-module, rd_lat_pipe: a parameterised valid+index delay line of depth RD_LATENCY, reused by other OCM readers.

Test Plan:
- Nominal load, LENGTH=5, RD_LATENCY=1, BASE_ADDR=0x10, OCM words 0x…0001_0003 to 0x…0005_0003:
  - reads at addresses 0x10..0x14 on consecutive cycles;
  - load_mem asserted 7 consecutive cycles with location 0,1,2,3,4,4,4 and matching data;
  - done_wait driven at the 7th beat+2 gives loaded=1 one cycle later; busy falls in the same cycle.
- RD_LATENCY=3: first load_mem 4 cycles after the first ocm_rd_en; order and count are unchanged.
- Timeout, TIMEOUT_CYCLES=16, done_wait held 0:
  - timeout_err=1 and busy=0 sixteen cycles after entering WAIT_DONE;
  - a subsequent start clears timeout_err and reloads.
- Reset mid-READ (rst pulsed on the 3rd read cycle): all outputs 0 asynchronously; no load_mem after release until a new start.
- start pulsed during TRAIL: ignored, with beat count still LENGTH+TRAILER_BEATS. start in LOADED: loaded drops next cycle and a full reload is observed.
- done_wait already 1 on WAIT_DONE entry: LOADED follows after exactly 1 cycle.

Source files
------------

// File: rtl/rx_cfg_pkg.sv
// Shared types and constants for the receiver configuration path.
package rx_cfg_pkg;

  // Width of one on-chip memory word.
  localparam int OCM_WORD_W = 64;

  // Field positions inside a pulse-response word.
  localparam int COEF_M_HI = 31;
  localparam int COEF_M_LO = 16;
  localparam int COEF_Y_HI = 15;
  localparam int COEF_Y_LO = 0;

  // Coefficient loader sequencing.
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_TRAIL,
    S_WAIT_DONE,
    S_LOADED,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid + index delay line matching a fixed-latency memory read.
// The entry leaving the last stage lines up with the read data it tags.
module rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Shift the issued read tags one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      idx_q[0] <= in_idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_idx_o   = idx_q[DEPTH-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/dfe_coef_loader.sv
// Streams pulse-response coefficients from on-chip memory into the DFE
// load port, pads with trailer beats, then waits for the DFE to confirm.
module dfe_coef_loader
  import rx_cfg_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int RD_LATENCY            = 1,
  parameter int BASE_ADDR             = 0,
  parameter int ADDR_WIDTH            = 10,
  parameter int TRAILER_BEATS         = 2,
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ocm_rd_en,
  output logic [ADDR_WIDTH-1:0] ocm_addr,
  input  logic [OCM_WORD_W-1:0] ocm_rdata,
  output logic                  load_mem,
  output logic [7:0]            location,
  output logic [OCM_WORD_W-1:0] mem_data,
  input  logic                  done_wait,
  output logic                  busy,
  output logic                  loaded,
  output logic                  timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TRL_W = $clog2(TRAILER_BEATS + 1) + 1;

  localparam logic [7:0]            LAST_IDX = 8'(PULSE_RESPONSE_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRL_W-1:0]      TRL_LAST = TRL_W'(TRAILER_BEATS);

  loader_state_t             state_q;
  logic                      rd_en_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                rd_idx_q;
  logic                      load_mem_q;
  logic [7:0]                location_q;
  logic [OCM_WORD_W-1:0]     mem_data_q;
  logic                      busy_q;
  logic                      loaded_q;
  logic                      timeout_err_q;
  logic [TMO_W-1:0]          tmo_cnt_q;
  logic [TRL_W-1:0]          trail_cnt_q;

  logic                      pipe_vld;
  logic [7:0]                pipe_idx;
  logic                      pipe_any;

  rd_lat_pipe #(
    .DEPTH (RD_LATENCY),
    .IDX_W (8)
  ) u_rd_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_en_q),
    .in_idx_i    (rd_idx_q),
    .out_valid_o (pipe_vld),
    .out_idx_o   (pipe_idx),
    .any_valid_o (pipe_any)
  );

  // Sequencer plus registered return path; trailer beats reuse the held
  // location/data so the DFE sees an idempotent rewrite of the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      rd_idx_q      <= '0;
      load_mem_q    <= 1'b0;
      location_q    <= '0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      loaded_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      trail_cnt_q   <= '0;
    end else begin
      load_mem_q <= pipe_vld;
      if (pipe_vld) begin
        location_q <= pipe_idx;
        mem_data_q <= ocm_rdata;
      end

      unique case (state_q)
        S_IDLE, S_LOADED, S_ERROR: begin
          if (start) begin
            state_q       <= S_READ;
            busy_q        <= 1'b1;
            loaded_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            rd_en_q       <= 1'b1;
            addr_q        <= BASE_A;
            rd_idx_q      <= '0;
            trail_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
          end
        end
        S_READ: begin
          if (rd_idx_q == LAST_IDX) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            rd_idx_q <= rd_idx_q + 8'd1;
            addr_q   <= addr_q + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          // Pipe empty means the last real beat is on the output this cycle.
          if (!pipe_any) begin
            if (TRAILER_BEATS == 0) begin
              state_q   <= S_WAIT_DONE;
              tmo_cnt_q <= '0;
            end else begin
              state_q     <= S_TRAIL;
              load_mem_q  <= 1'b1;
              trail_cnt_q <= TRL_W'(1);
            end
          end
        end
        S_TRAIL: begin
          if (trail_cnt_q == TRL_LAST) begin
            state_q   <= S_WAIT_DONE;
            tmo_cnt_q <= '0;
          end else begin
            load_mem_q  <= 1'b1;
            trail_cnt_q <= trail_cnt_q + TRL_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (done_wait) begin
            state_q  <= S_LOADED;
            loaded_q <= 1'b1;
            busy_q   <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q       <= S_ERROR;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ocm_rd_en   = rd_en_q;
  assign ocm_addr    = addr_q;
  assign load_mem    = load_mem_q;
  assign location    = location_q;
  assign mem_data    = mem_data_q;
  assign busy        = busy_q;
  assign loaded      = loaded_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dfe_coef_loader.sv
// Directed bench for dfe_coef_loader: instance A (latency 1, short timeout)
// and instance B (latency 3, base address wrapping past the top of memory).
module tb_dfe_coef_loader;
  import rx_cfg_pkg::*;

  localparam int LEN    = 5;
  localparam int TRL    = 2;
  localparam int BASE_A = 'h10;
  localparam int BASE_B = 'h3FE;

  typedef struct packed {
    logic [7:0]  loc;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // Instance A signals
  logic        start_a, done_wait_a;
  logic        ocm_rd_en_a, load_mem_a, busy_a, loaded_a, timeout_err_a;
  logic [9:0]  ocm_addr_a;
  logic [63:0] ocm_rdata_a, mem_data_a;
  logic [7:0]  location_a;
  // Instance B signals
  logic        start_b, done_wait_b;
  logic        ocm_rd_en_b, load_mem_b, busy_b, loaded_b, timeout_err_b;
  logic [9:0]  ocm_addr_b;
  logic [63:0] ocm_rdata_b, mem_data_b;
  logic [7:0]  location_b;

  dfe_coef_loader #(
    .PULSE_RESPONSE_LENGTH (LEN), .RD_LATENCY (1), .BASE_ADDR (BASE_A),
    .ADDR_WIDTH (10), .TRAILER_BEATS (TRL), .TIMEOUT_CYCLES (16)
  ) dut_a (
    .clk (clk), .rst (rst), .start (start_a),
    .ocm_rd_en (ocm_rd_en_a), .ocm_addr (ocm_addr_a), .ocm_rdata (ocm_rdata_a),
    .load_mem (load_mem_a), .location (location_a), .mem_data (mem_data_a),
    .done_wait (done_wait_a), .busy (busy_a), .loaded (loaded_a),
    .timeout_err (timeout_err_a)
  );

  dfe_coef_loader #(
    .PULSE_RESPONSE_LENGTH (LEN), .RD_LATENCY (3), .BASE_ADDR (BASE_B),
    .ADDR_WIDTH (10), .TRAILER_BEATS (TRL), .TIMEOUT_CYCLES (1024)
  ) dut_b (
    .clk (clk), .rst (rst), .start (start_b),
    .ocm_rd_en (ocm_rd_en_b), .ocm_addr (ocm_addr_b), .ocm_rdata (ocm_rdata_b),
    .load_mem (load_mem_b), .location (location_b), .mem_data (mem_data_b),
    .done_wait (done_wait_b), .busy (busy_b), .loaded (loaded_b),
    .timeout_err (timeout_err_b)
  );

  // Coefficient word i: m = i+1, y = 3, tagged upper half.
  function automatic logic [63:0] word_of(input int i);
    return {16'hA5A5, 16'(i), 16'(i + 1), 16'h0003};
  endfunction

  // OCM models
  logic [63:0] mem_a [1024];
  logic [63:0] mem_b [1024];
  logic [63:0] b_d1, b_d2, b_d3;
  always @(posedge clk) begin
    ocm_rdata_a <= mem_a[ocm_addr_a];
    b_d1 <= mem_b[ocm_addr_b];
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign ocm_rdata_b = b_d3;

  // Scoreboards
  logic [9:0] exp_addr_a [$];
  logic [9:0] exp_addr_b [$];
  beat_t      exp_beat_a [$];
  beat_t      exp_beat_b [$];

  int first_rd_a = -1, first_beat_a = -1, last_beat_a = -1, beat_cnt_a = 0;
  int first_rd_b = -1, first_beat_b = -1, last_beat_b = -1, beat_cnt_b = 0;
  logic prev_loaded_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_load_a();
    for (int i = 0; i < LEN; i++) begin
      exp_addr_a.push_back(10'(BASE_A + i));
      exp_beat_a.push_back('{loc: 8'(i), data: word_of(i)});
    end
    for (int t = 0; t < TRL; t++)
      exp_beat_a.push_back('{loc: 8'(LEN - 1), data: word_of(LEN - 1)});
    first_rd_a   = -1;
    first_beat_a = -1;
  endtask

  task automatic push_load_b();
    for (int i = 0; i < LEN; i++) begin
      exp_addr_b.push_back(10'(BASE_B + i));
      exp_beat_b.push_back('{loc: 8'(i), data: word_of(i)});
    end
    for (int t = 0; t < TRL; t++)
      exp_beat_b.push_back('{loc: 8'(LEN - 1), data: word_of(LEN - 1)});
    first_rd_b   = -1;
    first_beat_b = -1;
  endtask

  // Wait until A has emitted target beats and load_mem has dropped.
  task automatic wait_a_beats(input int target);
    int n = 0;
    while (!(beat_cnt_a == target && load_mem_a == 1'b0) && n < 80) begin
      step();
      n++;
    end
    chk("wait_beats_a", 64'(beat_cnt_a), 64'(target));
  endtask

  // Monitor A
  always @(negedge clk) begin
    beat_t eb;
    if (ocm_rd_en_a) begin
      if (first_rd_a < 0) first_rd_a = cyc;
      if (exp_addr_a.size() == 0) chk("rd_unexpected_a", 64'(ocm_rd_en_a), 64'd0);
      else chk("rd_addr_a", 64'(ocm_addr_a), 64'(exp_addr_a.pop_front()));
    end
    if (load_mem_a) begin
      if (first_beat_a < 0) first_beat_a = cyc;
      last_beat_a = cyc;
      beat_cnt_a++;
      $display("A beat loc=%0d m=%0h y=%0h", location_a,
               mem_data_a[COEF_M_HI:COEF_M_LO], mem_data_a[COEF_Y_HI:COEF_Y_LO]);
      if (exp_beat_a.size() == 0) chk("beat_unexpected_a", 64'(load_mem_a), 64'd0);
      else begin
        eb = exp_beat_a.pop_front();
        chk("beat_loc_a", 64'(location_a), 64'(eb.loc));
        chk("beat_data_a", mem_data_a, eb.data);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    beat_t eb;
    if (ocm_rd_en_b) begin
      if (first_rd_b < 0) first_rd_b = cyc;
      if (exp_addr_b.size() == 0) chk("rd_unexpected_b", 64'(ocm_rd_en_b), 64'd0);
      else chk("rd_addr_b", 64'(ocm_addr_b), 64'(exp_addr_b.pop_front()));
    end
    if (load_mem_b) begin
      if (first_beat_b < 0) first_beat_b = cyc;
      last_beat_b = cyc;
      beat_cnt_b++;
      $display("B beat loc=%0d m=%0h y=%0h", location_b,
               mem_data_b[COEF_M_HI:COEF_M_LO], mem_data_b[COEF_Y_HI:COEF_Y_LO]);
      if (exp_beat_b.size() == 0) chk("beat_unexpected_b", 64'(load_mem_b), 64'd0);
      else begin
        eb = exp_beat_b.pop_front();
        chk("beat_loc_b", 64'(location_b), 64'(eb.loc));
        chk("beat_data_b", mem_data_b, eb.data);
      end
    end
    // done_wait_b is held high, so loaded follows the last trailer beat by 2.
    if (loaded_b && !prev_loaded_b)
      chk("b_loaded_latency", 64'(cyc - last_beat_b), 64'd2);
    prev_loaded_b = loaded_b;
  end

  initial begin
    int base;
    for (int j = 0; j < 1024; j++) begin
      mem_a[j] = 64'hDEAD_0000_0000_0000 | 64'(j);
      mem_b[j] = 64'hBEEF_0000_0000_0000 | 64'(j);
    end
    for (int i = 0; i < LEN; i++) begin
      mem_a[10'(BASE_A + i)] = word_of(i);
      mem_b[10'(BASE_B + i)] = word_of(i);
    end
    start_a = 1'b0; start_b = 1'b0;
    done_wait_a = 1'b0; done_wait_b = 1'b1;
    rst = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_loaded_a", 64'(loaded_a), 64'd0);
    chk("rst_tmo_a", 64'(timeout_err_a), 64'd0);
    chk("rst_load_mem_a", 64'(load_mem_a), 64'd0);
    chk("rst_rd_en_a", 64'(ocm_rd_en_a), 64'd0);
    chk("rst_addr_a", 64'(ocm_addr_a), 64'd0);
    chk("rst_data_a", mem_data_a, 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    rst = 1'b0;
    step();

    // Nominal load on both instances
    push_load_a();
    push_load_b();
    start_a = 1'b1; start_b = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    chk("busy_after_start_a", 64'(busy_a), 64'd1);
    wait_a_beats(7);
    chk("a_first_latency", 64'(first_beat_a - first_rd_a), 64'd2);
    chk("a_contiguous", 64'(last_beat_a - first_beat_a), 64'd6);
    chk("a_busy_wait", 64'(busy_a), 64'd1);
    step();
    done_wait_a = 1'b1;
    chk("a_loaded_before", 64'(loaded_a), 64'd0);
    step();
    done_wait_a = 1'b0;
    chk("a_loaded", 64'(loaded_a), 64'd1);
    chk("a_busy_fall", 64'(busy_a), 64'd0);
    begin
      int n = 0;
      while (!loaded_b && n < 40) begin step(); n++; end
    end
    chk("b_loaded", 64'(loaded_b), 64'd1);
    chk("b_first_latency", 64'(first_beat_b - first_rd_b), 64'd4);
    chk("b_beats", 64'(beat_cnt_b), 64'd7);
    chk("b_contiguous", 64'(last_beat_b - first_beat_b), 64'd6);

    // Start in LOADED reloads; start during TRAIL ignored; then timeout
    base = beat_cnt_a;
    push_load_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("reload_loaded_drop", 64'(loaded_a), 64'd0);
    chk("reload_busy", 64'(busy_a), 64'd1);
    begin
      int n = 0;
      while (beat_cnt_a != base + 6 && n < 40) begin step(); n++; end
    end
    chk("trail_load_mem", 64'(load_mem_a), 64'd1);
    chk("trail_location", 64'(location_a), 64'(LEN - 1));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_a_beats(base + 7);
    chk("wait_busy", 64'(busy_a), 64'd1);
    repeat (15) step();
    chk("tmo_not_yet", 64'(timeout_err_a), 64'd0);
    chk("tmo_busy_still", 64'(busy_a), 64'd1);
    step();
    chk("tmo_err", 64'(timeout_err_a), 64'd1);
    chk("tmo_busy", 64'(busy_a), 64'd0);
    repeat (3) step();
    chk("tmo_sticky", 64'(timeout_err_a), 64'd1);
    chk("trail_start_ignored", 64'(beat_cnt_a), 64'(base + 7));

    // Start from ERROR clears the error and reloads
    base = beat_cnt_a;
    push_load_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("err_cleared", 64'(timeout_err_a), 64'd0);
    chk("err_reload_busy", 64'(busy_a), 64'd1);
    wait_a_beats(base + 7);
    done_wait_a = 1'b1;
    step();
    done_wait_a = 1'b0;
    chk("err_reload_loaded", 64'(loaded_a), 64'd1);

    // Reset in the third READ cycle
    base = beat_cnt_a;
    push_load_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("third_read_en", 64'(ocm_rd_en_a), 64'd1);
    chk("third_read_addr", 64'(ocm_addr_a), 64'(BASE_A + 2));
    rst = 1'b1;
    #1;
    chk("arst_rd_en", 64'(ocm_rd_en_a), 64'd0);
    chk("arst_addr", 64'(ocm_addr_a), 64'd0);
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_load_mem", 64'(load_mem_a), 64'd0);
    chk("arst_location", 64'(location_a), 64'd0);
    chk("arst_data", mem_data_a, 64'd0);
    exp_addr_a.delete();
    exp_beat_a.delete();
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("no_beats_after_reset", 64'(beat_cnt_a), 64'(base));
    chk("idle_after_reset", 64'(busy_a), 64'd0);

    // Fresh load after reset
    push_load_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_a_beats(base + 7);
    done_wait_a = 1'b1;
    step();
    done_wait_a = 1'b0;
    chk("post_reset_loaded", 64'(loaded_a), 64'd1);
    chk("scoreboard_empty_a", 64'(exp_beat_a.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
